// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-ROM read-port arbiter.
package imem_arb_pkg;

    // Width of the debug starvation counter.
    localparam int STARVE_W = 4;

    // ROM micro-instruction encoding seen on mem_instruction.
    localparam int                  MEM_OP_W     = 2;
    localparam logic [MEM_OP_W-1:0] MEM_NONE     = 2'd0;
    localparam logic [MEM_OP_W-1:0] MEM_LDINSTRC = 2'd1;

    // Owner and status of the read issued in the previous cycle.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESP_FETCH = 3'd1,
        RESP_DBG   = 3'd2,
        ERR_FETCH  = 3'd3,
        ERR_DBG    = 3'd4
    } resp_state_e;

endpackage

// File: rtl/imem_arb_select.sv
// Fixed-priority grant selection: fetch wins unless debug has waited
// STARVE_LIMIT consecutive fetch grants.
module imem_arb_select
    import imem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                block_i,
    input  logic                fetch_req_i,
    input  logic                dbg_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                fetch_gnt_o,
    output logic                dbg_gnt_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    // At most one grant per cycle; block_i suppresses all grants.
    always_comb begin
        fetch_gnt_o = 1'b0;
        dbg_gnt_o   = 1'b0;
        if (!block_i) begin
            if (fetch_req_i && dbg_req_i) begin
                if (starve_cnt_i == LIMIT) begin
                    dbg_gnt_o = 1'b1;
                end else begin
                    fetch_gnt_o = 1'b1;
                end
            end else if (fetch_req_i) begin
                fetch_gnt_o = 1'b1;
            end else if (dbg_req_i) begin
                dbg_gnt_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction ROM's registered read port between the CPU fetch
// path and a debug port, routing each 1-cycle-latency response back to its
// owner. Out-of-range addresses are answered with an error, ROM untouched.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_gnt,
    output logic                fetch_rvalid,
    output logic [DATA_W-1:0]   fetch_rdata,
    output logic                fetch_err,
    input  logic                dbg_req,
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                dbg_err,
    output logic [MEM_OP_W-1:0] mem_instruction,
    output logic [ADDR_W-1:0]   mem_pc,
    input  logic [DATA_W-1:0]   rom_instruction
);

    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [STARVE_W-1:0]   LIMIT   = STARVE_W'(STARVE_LIMIT);

    resp_state_e         state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                gnt_any;
    logic                gnt_in_range;

    imem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .block_i      (reset),
        .fetch_req_i  (fetch_req),
        .dbg_req_i    (dbg_req),
        .starve_cnt_i (starve_q),
        .fetch_gnt_o  (fetch_gnt),
        .dbg_gnt_o    (dbg_gnt)
    );

    assign gnt_any      = fetch_gnt | dbg_gnt;
    assign gnt_addr     = fetch_gnt ? fetch_addr : dbg_addr;
    assign gnt_in_range = ({1'b0, gnt_addr} < DEPTH_L);

    // Drive the ROM in the grant cycle; the address holds when idle.
    always_comb begin
        mem_instruction = MEM_NONE;
        pc_d            = pc_q;
        if (gnt_any) begin
            if (gnt_in_range) begin
                mem_instruction = MEM_LDINSTRC;
                pc_d            = gnt_addr;
            end else begin
                pc_d            = '0;
            end
        end
    end

    assign mem_pc = reset ? '0 : pc_d;

    // Debug waiting behind fetch counts up (saturating); any debug grant
    // or absent debug request clears it.
    always_comb begin
        starve_d = starve_q;
        if (dbg_gnt || !dbg_req) begin
            starve_d = '0;
        end else if (fetch_gnt && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Next response state: owner/status of this cycle's grant.
    always_comb begin
        state_d = IDLE;
        if (fetch_gnt) begin
            state_d = gnt_in_range ? RESP_FETCH : ERR_FETCH;
        end else if (dbg_gnt) begin
            state_d = gnt_in_range ? RESP_DBG : ERR_DBG;
        end
    end

    // State, starvation counter and held ROM address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            pc_q     <= pc_d;
        end
    end

    // Response routing; a pending response is dropped while reset is high.
    always_comb begin
        fetch_rvalid = 1'b0;
        fetch_rdata  = '0;
        fetch_err    = 1'b0;
        dbg_rvalid   = 1'b0;
        dbg_rdata    = '0;
        dbg_err      = 1'b0;
        if (!reset) begin
            case (state_q)
                RESP_FETCH: begin
                    fetch_rvalid = 1'b1;
                    fetch_rdata  = rom_instruction;
                end
                RESP_DBG: begin
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = rom_instruction;
                end
                ERR_FETCH: begin
                    fetch_rvalid = 1'b1;
                    fetch_err    = 1'b1;
                end
                ERR_DBG: begin
                    dbg_rvalid = 1'b1;
                    dbg_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed request vectors push the
// expected response; a negedge monitor pops and compares each response.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                fetch_req;
    logic [AW-1:0]       fetch_addr;
    logic                fetch_gnt;
    logic                fetch_rvalid;
    logic [DW-1:0]       fetch_rdata;
    logic                fetch_err;
    logic                dbg_req;
    logic [AW-1:0]       dbg_addr;
    logic                dbg_gnt;
    logic                dbg_rvalid;
    logic [DW-1:0]       dbg_rdata;
    logic                dbg_err;
    logic [MEM_OP_W-1:0] mem_instruction;
    logic [AW-1:0]       mem_pc;
    logic [DW-1:0]       rom_q;

    logic [DW-1:0] rom [0:2047];

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_pc = '0;

    imem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MEM_DEPTH    (256),
        .STARVE_LIMIT (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_gnt       (fetch_gnt),
        .fetch_rvalid    (fetch_rvalid),
        .fetch_rdata     (fetch_rdata),
        .fetch_err       (fetch_err),
        .dbg_req         (dbg_req),
        .dbg_addr        (dbg_addr),
        .dbg_gnt         (dbg_gnt),
        .dbg_rvalid      (dbg_rvalid),
        .dbg_rdata       (dbg_rdata),
        .dbg_err         (dbg_err),
        .mem_instruction (mem_instruction),
        .mem_pc          (mem_pc),
        .rom_instruction (rom_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read ROM model.
    always @(posedge clk) begin
        if (mem_instruction == MEM_LDINSTRC) rom_q <= rom[mem_pc];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("rst fetch_rvalid", fetch_rvalid, 0);
            chk("rst dbg_rvalid", dbg_rvalid, 0);
            chk("rst fetch_rdata", fetch_rdata, 0);
            chk("rst dbg_rdata", dbg_rdata, 0);
        end else begin
            if (fq.size() > 0 && fq[0].due == cyc) begin
                e = fq.pop_front();
                chk("fetch_rvalid", fetch_rvalid, 1);
                chk("fetch_rdata", fetch_rdata, e.data);
                chk("fetch_err", fetch_err, e.err);
                $display("[%0d] fetch resp data=%0h err=%0b", cyc, fetch_rdata, fetch_err);
            end else begin
                chk("fetch idle rvalid", fetch_rvalid, 0);
                chk("fetch idle rdata", fetch_rdata, 0);
                chk("fetch idle err", fetch_err, 0);
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                chk("dbg_rvalid", dbg_rvalid, 1);
                chk("dbg_rdata", dbg_rdata, e.data);
                chk("dbg_err", dbg_err, e.err);
                $display("[%0d] dbg resp data=%0h err=%0b", cyc, dbg_rdata, dbg_err);
            end else begin
                chk("dbg idle rvalid", dbg_rvalid, 0);
                chk("dbg idle rdata", dbg_rdata, 0);
                chk("dbg idle err", dbg_err, 0);
            end
        end
    end

    // One cycle of stimulus with expected grant and (if granted) response.
    task automatic step(input bit rst, input bit fr, input logic [AW-1:0] fa,
                        input bit dr, input logic [AW-1:0] da,
                        input bit efg, input bit edg,
                        input logic [31:0] ed, input bit ee);
        exp_t          e;
        logic [AW-1:0] ga;
        @(posedge clk);
        #1;
        reset      = rst;
        fetch_req  = fr;
        fetch_addr = fa;
        dbg_req    = dr;
        dbg_addr   = da;
        if (rst) begin
            fq.delete();
            dq.delete();
            exp_pc = '0;
        end
        @(negedge clk);
        chk("fetch_gnt", fetch_gnt, efg);
        chk("dbg_gnt", dbg_gnt, edg);
        if (efg || edg) begin
            ga     = efg ? fa : da;
            exp_pc = ee ? '0 : ga;
            chk("mem_instruction", mem_instruction, ee ? MEM_NONE : MEM_LDINSTRC);
            e.due  = cyc + 1;
            e.data = ed;
            e.err  = ee;
            if (efg) fq.push_back(e);
            else     dq.push_back(e);
        end else begin
            chk("mem_instruction idle", mem_instruction, MEM_NONE);
        end
        chk("mem_pc", mem_pc, exp_pc);
        $display("[%0d] rst=%0b freq=%0b fa=%0d dreq=%0b da=%0d -> fgnt=%0b dgnt=%0b pc=%0d",
                 cyc, rst, fr, fa, dr, da, fetch_gnt, dbg_gnt, mem_pc);
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
        rom_q = '0;
        for (int i = 0; i < 2048; i++) rom[i] = 32'h10 + i;
        rom[255] = 32'hAB;

        // Reset: requests present but no grants.
        step(1, 0, 0, 0, 0,   0, 0, 0, 0);
        step(1, 1, 0, 1, 0,   0, 0, 0, 0);
        step(0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Fetch only, back to back.
        step(0, 1, 0, 0, 0,   1, 0, 32'h10, 0);
        step(0, 1, 1, 0, 0,   1, 0, 32'h11, 0);
        step(0, 1, 2, 0, 0,   1, 0, 32'h12, 0);
        step(0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Both held: F,F,F,F,D,F,F,F,F,D.
        step(0, 1, 3,  1, 100, 1, 0, 32'h13, 0);
        step(0, 1, 4,  1, 100, 1, 0, 32'h14, 0);
        step(0, 1, 5,  1, 100, 1, 0, 32'h15, 0);
        step(0, 1, 6,  1, 100, 1, 0, 32'h16, 0);
        step(0, 1, 7,  1, 100, 0, 1, 32'h74, 0);
        step(0, 1, 7,  1, 101, 1, 0, 32'h17, 0);
        step(0, 1, 8,  1, 101, 1, 0, 32'h18, 0);
        step(0, 1, 9,  1, 101, 1, 0, 32'h19, 0);
        step(0, 1, 10, 1, 101, 1, 0, 32'h1A, 0);
        step(0, 1, 11, 1, 101, 0, 1, 32'h75, 0);
        step(0, 0, 0,  0, 0,   0, 0, 0, 0);

        // Range boundaries; the idle cycle checks that mem_pc holds.
        step(0, 1, 255, 0, 0,   1, 0, 32'hAB, 0);
        step(0, 0, 0,   0, 0,   0, 0, 0, 0);
        step(0, 0, 0,   1, 256, 0, 1, 0, 1);
        step(0, 1, 256, 0, 0,   1, 0, 0, 1);
        step(0, 0, 0,   1, 255, 0, 1, 32'hAB, 0);
        step(0, 0, 0,   0, 0,   0, 0, 0, 0);

        // Reset right after a grant discards the response.
        step(0, 1, 20, 0, 0, 1, 0, 32'h24, 0);
        step(1, 1, 21, 0, 0, 0, 0, 0, 0);
        step(0, 1, 21, 0, 0, 1, 0, 32'h25, 0);
        step(0, 0, 0,  0, 0, 0, 0, 0, 0);

        // Debug drops before grant: counter restarts from 0.
        step(0, 1, 30, 1, 40, 1, 0, 32'h2E, 0);
        step(0, 1, 31, 1, 40, 1, 0, 32'h2F, 0);
        step(0, 1, 32, 0, 0,  1, 0, 32'h30, 0);
        step(0, 1, 33, 1, 40, 1, 0, 32'h31, 0);
        step(0, 1, 34, 1, 40, 1, 0, 32'h32, 0);
        step(0, 1, 35, 1, 40, 1, 0, 32'h33, 0);
        step(0, 1, 36, 1, 40, 1, 0, 32'h34, 0);
        step(0, 1, 37, 1, 40, 0, 1, 32'h38, 0);
        step(0, 0, 0,  0, 0,  0, 0, 0, 0);
        step(0, 0, 0,  0, 0,  0, 0, 0, 0);

        chk("fetch queue drained", fq.size(), 0);
        chk("dbg queue drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
